// File: rtl/bin_to_bcd8.sv
// rtl/bin_to_bcd8.sv - sequential double-dabble binary to eight-digit BCD converter
//
// Purpose: converts an unsigned IN_W-bit value to eight BCD digits plus an
// overflow flag, one binary bit per clock, for the seven-segment display
// controller. A ninth working digit exists only to detect values above
// 99,999,999.
//
// Build option: BCD_OVF_CLAMP_EN - when defined, an overflowing result
// shows all nines instead of the value mod 10^8.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   bin_i        value to convert, sampled on the accepting edge only
//   start_i      conversion request, honoured in IDLE only
//   digits_o     registered BCD result, [0] is the least-significant digit
//   busy_o       conversion in progress
//   done_o       one-cycle pulse when digits_o/overflow_o are new
//   overflow_o   last converted value exceeded 99,999,999
module bin_to_bcd8 #(
    parameter int IN_W = 27
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [IN_W-1:0] bin_i,
    input  logic            start_i,
    output logic [3:0]      digits_o [0:7],
    output logic            busy_o,
    output logic            done_o,
    output logic            overflow_o
);

    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] bin_q, bin_d;
    logic [35:0]     bcd_q, bcd_d;
    logic [35:0]     bcd_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      digits_q [0:7];
    logic [3:0]      digits_d [0:7];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        // Add-3 correction so every digit carries correctly on the next doubling.
        bcd_adj = bcd_q;
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(IN_W);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = (bcd_adj << 1) | 36'(bin_q[IN_W-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                for (int i = 0; i < 8; i++) begin
                    digits_d[i] = bcd_q[4*i +: 4];
                end
                ovf_d = (bcd_q[35:32] != 4'd0);
`ifdef BCD_OVF_CLAMP_EN
                if (bcd_q[35:32] != 4'd0) begin
                    for (int i = 0; i < 8; i++) begin
                        digits_d[i] = 4'd9;
                    end
                end
`else
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                digits_q[i] <= 4'd0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign digits_o   = digits_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd8.sv
// tb/tb_bin_to_bcd8.sv - self-checking bench for bin_to_bcd8 (IN_W=27 and IN_W=4)
module tb_bin_to_bcd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [26:0] bin27 = '0;
    logic        start27 = 1'b0;
    logic [3:0]  dig27 [0:7];
    logic        busy27, done27, ovf27;
    logic [3:0]  bin4 = '0;
    logic        start4 = 1'b0;
    logic [3:0]  dig4 [0:7];
    logic        busy4, done4, ovf4;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected display contents, maintained by the reference model.
    logic [3:0] exp27 [0:7];
    logic       exp_ovf27;
    logic [3:0] exp4 [0:7];

    always #5 clk = ~clk;

    bin_to_bcd8 #(.IN_W(27)) dut27 (
        .clk_i(clk), .reset_i(reset), .bin_i(bin27), .start_i(start27),
        .digits_o(dig27), .busy_o(busy27), .done_o(done27), .overflow_o(ovf27)
    );

    bin_to_bcd8 #(.IN_W(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .bin_i(bin4), .start_i(start4),
        .digits_o(dig4), .busy_o(busy4), .done_o(done4), .overflow_o(ovf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal digit k of v as the display should show it.
    function automatic logic [3:0] ref_digit(input longint v, input int k, input bit clamp_ok);
        longint p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
`ifdef BCD_OVF_CLAMP_EN
        if (clamp_ok && v > 99999999) return 4'd9;
`endif
        return 4'((v / p) % 10);
    endfunction

    task automatic check_disp27(input string tag);
        for (int k = 0; k < 8; k++) check($sformatf("%s_dig%0d", tag, k), 64'(dig27[k]), 64'(exp27[k]));
        check({tag, "_ovf"}, 64'(ovf27), 64'(exp_ovf27));
    endtask

    task automatic check_disp4(input string tag);
        for (int k = 0; k < 8; k++) check($sformatf("%s_dig%0d", tag, k), 64'(dig4[k]), 64'(exp4[k]));
        check({tag, "_ovf"}, 64'(ovf4), 64'd0);
    endtask

    // Starts a conversion on the next edge and follows it to its done cycle.
    // disturb>0 pulses start with a different bin on that SHIFT edge.
    task automatic run27(input longint v, input int disturb, input string tag);
        start27 = 1'b1;
        bin27   = 27'(v);
        tick();
        start27 = 1'b0;
        bin27   = 27'($urandom);
        check({tag, "_busy_e0"}, 64'(busy27), 64'd1);
        check({tag, "_done_e0"}, 64'(done27), 64'd0);
        for (int i = 1; i <= 28; i++) begin
            if (i == disturb) begin
                start27 = 1'b1;
                bin27   = 27'd999;
            end else begin
                start27 = 1'b0;
            end
            tick();
            if (i < 28) begin
                check($sformatf("%s_busy_e%0d", tag, i), 64'(busy27), 64'd1);
                check($sformatf("%s_done_e%0d", tag, i), 64'(done27), 64'd0);
                if (i == 14) check_disp27({tag, "_hold"});
            end else begin
                for (int k = 0; k < 8; k++) exp27[k] = ref_digit(v, k, 1'b1);
                exp_ovf27 = (v > 99999999);
                check({tag, "_done"}, 64'(done27), 64'd1);
                check({tag, "_busy_end"}, 64'(busy27), 64'd0);
                check_disp27(tag);
            end
        end
        start27 = 1'b0;
    endtask

    task automatic run4(input int v, input string tag);
        start4 = 1'b1;
        bin4   = 4'(v);
        tick();
        start4 = 1'b0;
        bin4   = 4'($urandom);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i < 5) begin
                check($sformatf("%s_busy_e%0d", tag, i), 64'(busy4), 64'd1);
                check($sformatf("%s_done_e%0d", tag, i), 64'(done4), 64'd0);
            end else begin
                for (int k = 0; k < 8; k++) exp4[k] = ref_digit(v, k, 1'b0);
                check({tag, "_done"}, 64'(done4), 64'd1);
                check({tag, "_busy_end"}, 64'(busy4), 64'd0);
                check_disp4(tag);
            end
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin
            exp27[k] = 4'd0;
            exp4[k]  = 4'd0;
        end
        exp_ovf27 = 1'b0;
    endtask

    initial begin
        bit saw_done;
        clear_model();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy27), 64'd0);
        check("rst_done", 64'(done27), 64'd0);
        check_disp27("rst");
        check("rst4_busy", 64'(busy4), 64'd0);
        check_disp4("rst4");

        // 12,345,678: 28 busy cycles, done on edge 28
        tick();
        run27(64'd12345678, 0, "v12345678");
        tick();
        check("after1_done", 64'(done27), 64'd0);

        // 0 then 99,999,999 back-to-back, second start in the done cycle
        run27(64'd0, 0, "zero");
        run27(64'd99999999, 0, "nines");
        tick();

        // start and bin changed mid-conversion are ignored
        run27(64'd42, 5, "v42_dist");
        saw_done = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (done27 || busy27) saw_done = 1'b1;
        end
        check("v42_single_done", 64'(saw_done), 64'd0);

        // Overflow
        run27(64'd123456789, 0, "ovf");
        tick();

        // Reset at SHIFT cycle 10 of 555 aborts with no done
        start27 = 1'b1;
        bin27   = 27'd555;
        tick();
        start27 = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        check("abort_busy", 64'(busy27), 64'd0);
        check("abort_done", 64'(done27), 64'd0);
        check_disp27("abort");
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done27) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        run27(64'd7, 0, "seven");
        tick();

        // Randomized values, sometimes back-to-back
        for (int n = 0; n < 12; n++) begin
            longint v;
            v = longint'($urandom_range(0, 134217727));
            if (n % 3 == 0) v = longint'($urandom_range(0, 99999999));
            run27(v, (n % 4 == 1) ? int'($urandom_range(1, 27)) : 0, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) tick();
        end
        run27(64'd100000000, 0, "edge_1e8");
        run27(64'd134217727, 0, "edge_max");

        // Narrow instance: 15 then all values back-to-back
        tick();
        run4(15, "w4_15");
        for (int v = 0; v < 16; v++) run4(v, $sformatf("w4_%0d", v));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
